multiplicacao_seq: RTL and testbench
====================================

Name: multiplicacao_seq

Overview:
Sequential matrix-multiply engine for signed 8-bit matrices of size 2x2 to 5x5. It shares one 8x8 signed multiplier and one accumulator across all C elements, iterating i/j/k under an FSM, and trades latency for area against the fully combinational multiplier. It sits between the operand registers and the result bank and uses a start/busy/done handshake. The packed layout and size encoding are identical to the combinational multiply block, so the two are interchangeable at the result bank.

Parameters:
DATA_W, 8, element width (signed two's complement)
MAX_N, 5, maximum matrix dimension; packed buses are MAX_N*MAX_N*DATA_W = 200 bits
ACC_W, 18, accumulator width; holds 5*(-128*-128) = 81920 without wrap

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
matrix_size  input  2  00:2x2, 01:3x3, 10:4x4, 11:5x5; captured with start
A  input  200  operand A, element (r,c) at bits [r*40 + c*8 +: 8]
B  input  200  operand B, same layout
C  output  200  result, element (r,c) at bits [(r*5+c)*8 +: 8] = low 8 bits of sum
overflow_flag  output  1  sticky; 1 if any element sum is outside [-128,127]
busy  output  1  high while in CALC
done  output  1  one-cycle pulse when C/overflow_flag are final

Behaviour:
- Reset (async, rst_n=0): state=IDLE; C=0, overflow_flag=0, busy=0, done=0; i/j/k/acc=0; operand registers=0. A reset mid-operation abandons the run, and no done is produced.
- States: IDLE, CALC, DONE.
- IDLE: on an edge with start=1:
  - latch A, B and N (decoded from matrix_size);
  - clear C and overflow_flag;
  - set i=j=k=0, acc=0;
  - go to CALC.
  - Otherwise hold all outputs. C and the flag keep the last result.
- CALC: busy=1. Each edge performs one MAC: prod = sext(a(i,k)) * sext(b(k,j)), a full signed 16-bit product.
  - k<N-1: acc += prod; k++.
  - k==N-1: sum = acc + prod. Write sum[7:0] to element (i,j). If sum>127 or sum<-128, set overflow_flag. Then acc=0, k=0, and advance j; on j wrap, advance i.
  - After the MAC for (N-1,N-1,N-1), go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. start is ignored in DONE.
- Latency: N^3 edges from the start-sampling edge to entering DONE, so done rises N^3 cycles after start is accepted (2x2:8, 3x3:27, 4x4:64, 5x5:125).
- start while busy or in DONE: ignored and not queued. The operand latches are unaffected by input changes during CALC.
- C positions with row or column >= N stay 0.
- overflow_flag is sticky for the whole run and cleared only by reset or an accepted start.
- The accumulator never wraps for N<=5. Overflow detection uses the full ACC_W-bit sum, never the truncated byte.
- C is written per element during CALC, so intermediate values are visible. Consumers use C only at done or later.

Test Plan:
- 2x2, A=[[1,2],[3,4]], B=identity -> done 8 cycles after start; C elements (0,0..1,1)=1,2,3,4; all other bytes 0; overflow_flag=0.
- 3x3, A=B=all 10 -> each sum 300; every C element = 300 mod 256 = 0x2C; overflow_flag=1; done at cycle 27.
- 5x5, A=B=all -128 (0x80) -> each sum 81920; C bytes = 0x00; overflow_flag=1; done at cycle 125; accumulator shows no wrap.
- 4x4, A=identity, B = elements -1..-16 -> C=B, overflow_flag=0, done at cycle 64. Then start with new A/B in the next IDLE cycle -> C and flag cleared on acceptance and the new result produced.
- start pulses and operand changes during CALC of a 3x3 run -> no restart; the result matches the originally latched operands; exactly one done pulse.
- rst_n low at cycle 10 of a 5x5 run -> all outputs 0 immediately (async). After release the block is in IDLE with no done pulse, and a new 2x2 start completes normally in 8 cycles.

Source files
------------

// File: rtl/multiplicacao_seq.sv
// rtl/multiplicacao_seq.sv - sequential signed matrix multiply (2x2..5x5) with one shared MAC
// Computes one multiply-accumulate per clock, iterating i/j/k; done pulses when C is final.
module multiplicacao_seq #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5,
  parameter int ACC_W  = 18
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [1:0]                      matrix_size,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   A,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   B,
  output logic [MAX_N*MAX_N*DATA_W-1:0]   C,
  output logic                            overflow_flag,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                          r_state;
  logic [MAX_N*MAX_N*DATA_W-1:0]   r_a;
  logic [MAX_N*MAX_N*DATA_W-1:0]   r_b;
  logic [2:0]                      r_n;
  logic [2:0]                      r_i;
  logic [2:0]                      r_j;
  logic [2:0]                      r_k;
  logic signed [ACC_W-1:0]         r_acc;

  logic [2:0]                      w_last;
  logic [31:0]                     w_a_idx;
  logic [31:0]                     w_b_idx;
  logic [31:0]                     w_c_idx;
  logic signed [DATA_W-1:0]        w_a;
  logic signed [DATA_W-1:0]        w_b;
  logic signed [2*DATA_W-1:0]      w_prod;
  logic signed [ACC_W-1:0]         w_prod_ext;
  logic signed [ACC_W-1:0]         w_sum;
  logic                            w_ovf;

  assign w_last     = r_n - 3'd1;
  assign w_a_idx    = (32'(r_i) * MAX_N + 32'(r_k)) * DATA_W;
  assign w_b_idx    = (32'(r_k) * MAX_N + 32'(r_j)) * DATA_W;
  assign w_c_idx    = (32'(r_i) * MAX_N + 32'(r_j)) * DATA_W;
  assign w_a        = r_a[w_a_idx +: DATA_W];
  assign w_b        = r_b[w_b_idx +: DATA_W];
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  // Sum fits a signed byte only if all bits above the byte's sign bit match it.
  assign w_ovf      = !((&w_sum[ACC_W-1:DATA_W-1]) || !(|w_sum[ACC_W-1:DATA_W-1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_n           <= 3'd2;
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_acc         <= '0;
      C             <= '0;
      overflow_flag <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a           <= A;
            r_b           <= B;
            r_n           <= {1'b0, matrix_size} + 3'd2;
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            C             <= '0;
            overflow_flag <= 1'b0;
            busy          <= 1'b1;
            r_state       <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_k != w_last) begin
            r_acc <= w_sum;
            r_k   <= r_k + 3'd1;
          end else begin
            C[w_c_idx +: DATA_W] <= w_sum[DATA_W-1:0];
            if (w_ovf) overflow_flag <= 1'b1;
            r_acc <= '0;
            r_k   <= '0;
            if (r_j != w_last) begin
              r_j <= r_j + 3'd1;
            end else begin
              r_j <= '0;
              if (r_i != w_last) begin
                r_i <= r_i + 3'd1;
              end else begin
                r_i     <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicacao_seq.sv
// tb/tb_multiplicacao_seq.sv - directed scoreboard bench for multiplicacao_seq
module tb_multiplicacao_seq;

  typedef struct {
    logic [199:0] c;
    logic         ovf;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   matrix_size = 2'b00;
  logic [199:0] A = '0;
  logic [199:0] B = '0;
  logic [199:0] C;
  logic         overflow_flag;
  logic         busy;
  logic         done;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [199:0] ma, mb;
  bit   extra_done;

  multiplicacao_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
    .A(A), .B(B), .C(C), .overflow_flag(overflow_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [199:0] a, input logic [199:0] b, input int n);
    exp_t e;
    int   s;
    logic signed [7:0] ea, eb;
    e.c   = '0;
    e.ovf = 1'b0;
    e.lat = n * n * n;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          ea = a[(r*5+k)*8 +: 8];
          eb = b[(k*5+c)*8 +: 8];
          s  = s + int'(ea) * int'(eb);
        end
        e.c[(r*5+c)*8 +: 8] = s[7:0];
        if (s > 127 || s < -128) e.ovf = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [199:0] rnd200();
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  // Called on a negedge with the DUT idle; returns on the negedge after done has fallen.
  task automatic run(input logic [1:0] sz, input logic [199:0] a, input logic [199:0] b,
                     input bit disturb, input string tag);
    exp_t e;
    int   cyc;
    check({tag, "_idle_busy"}, 200'(busy), 200'(0));
    A = a; B = b; matrix_size = sz; start = 1'b1;
    sb.push_back(model(a, b, int'(sz) + 2));
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clear_c"}, C, '0);
    check({tag, "_clear_ovf"}, 200'(overflow_flag), 200'(0));
    check({tag, "_busy"}, 200'(busy), 200'(1));
    cyc = 0;
    while (cyc < 300 && !done) begin
      if (disturb) begin
        start       = ((cyc % 5) == 2);
        A           = rnd200();
        B           = rnd200();
        matrix_size = 2'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 200'(done), 200'(1));
    e = sb.pop_front();
    check({tag, "_latency"}, 200'(cyc), 200'(e.lat));
    check({tag, "_c"}, C, e.c);
    check({tag, "_ovf"}, 200'(overflow_flag), 200'(e.ovf));
    check({tag, "_busy_at_done"}, 200'(busy), 200'(0));
    @(negedge clk);
    check({tag, "_done_pulse"}, 200'(done), 200'(0));
  endtask

  initial begin
    #12;
    check("rst_c", C, '0);
    check("rst_ovf", 200'(overflow_flag), 200'(0));
    check("rst_busy", 200'(busy), 200'(0));
    check("rst_done", 200'(done), 200'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2: [[1,2],[3,4]] x identity
    ma = '0; mb = '0;
    ma[0*8 +: 8] = 8'd1; ma[1*8 +: 8] = 8'd2; ma[5*8 +: 8] = 8'd3; ma[6*8 +: 8] = 8'd4;
    mb[0*8 +: 8] = 8'd1; mb[6*8 +: 8] = 8'd1;
    run(2'b00, ma, mb, 1'b0, "n2_ident");
    check("n2_c_literal", C, 200'h0000_0000_0000_0000_0000_0000_0000_0004_0300_0000_0201);

    // 3x3 all 10s (bytes outside 3x3 also 10, must be ignored)
    for (int i = 0; i < 25; i++) begin ma[i*8 +: 8] = 8'd10; mb[i*8 +: 8] = 8'd10; end
    run(2'b01, ma, mb, 1'b0, "n3_tens");
    check("n3_c11_literal", 200'(C[6*8 +: 8]), 200'(8'h2C));
    check("n3_c33_zero", 200'(C[18*8 +: 8]), 200'(0));

    // 5x5 all -128: largest accumulator magnitude
    for (int i = 0; i < 25; i++) begin ma[i*8 +: 8] = 8'h80; mb[i*8 +: 8] = 8'h80; end
    run(2'b11, ma, mb, 1'b0, "n5_min");
    check("n5_ovf_literal", 200'(overflow_flag), 200'(1));

    // 4x4 identity x (-1..-16), then immediate restart in the next idle cycle
    ma = '0; mb = '0;
    for (int r = 0; r < 4; r++) begin
      ma[(r*5+r)*8 +: 8] = 8'd1;
      for (int c = 0; c < 4; c++) mb[(r*5+c)*8 +: 8] = 8'(-(r*4+c+1));
    end
    run(2'b10, ma, mb, 1'b0, "n4_ident");
    check("n4_c_equals_b", C, mb);
    run(2'b01, rnd200(), rnd200(), 1'b0, "n3_back2back");

    // start pulses and operand churn during CALC must not restart the run
    run(2'b01, rnd200(), rnd200(), 1'b1, "n3_disturb");
    extra_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra_done = 1'b1;
    end
    check("n3_disturb_no_requeue", 200'(extra_done), 200'(0));

    // asynchronous reset in the middle of a 5x5 run
    A = rnd200(); B = rnd200(); matrix_size = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_c", C, '0);
    check("arst_ovf", 200'(overflow_flag), 200'(0));
    check("arst_busy", 200'(busy), 200'(0));
    check("arst_done", 200'(done), 200'(0));
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 1'b0;
    repeat (140) begin
      @(negedge clk);
      if (done || busy) extra_done = 1'b1;
    end
    check("arst_no_done", 200'(extra_done), 200'(0));
    run(2'b00, rnd200(), rnd200(), 1'b0, "n2_after_rst");

    check("sb_empty", 200'(sb.size()), 200'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
